// File: rtl/s_machine_pkg.sv
// Shared S-Machine definitions: datapath widths, opcode field, opcodes, fetch states.
package s_machine_pkg;

  localparam int unsigned S_ADDR_W = 8;
  localparam int unsigned S_INST_W = 16;

  localparam int unsigned OP_MSB = 15;
  localparam int unsigned OP_LSB = 12;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ALU  = 4'b0001;
  localparam logic [3:0] OP_LDI  = 4'b0010;
  localparam logic [3:0] OP_BR   = 4'b0100;
  localparam logic [3:0] OP_HALT = 4'b1000;

  typedef enum logic [0:0] {
    StRun  = 1'b0,
    StHalt = 1'b1
  } fetch_state_e;

  function automatic logic [3:0] get_op(input logic [S_INST_W-1:0] inst);
    return inst[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/pc_counter.sv
// Program counter: async reset to RESET_PC, then load, increment or hold (wraps modulo 2^ADDR_W).
module pc_counter #(
  parameter int unsigned       ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load_en) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// S-Machine fetch stage: PC, instruction register and valid/ready handoff to decode.
// Optional HALT opcode stop is enabled by defining FETCH_HALT_EN.
module fetch_unit
  import s_machine_pkg::*;
#(
  parameter int unsigned       ADDR_W   = S_ADDR_W,
  parameter int unsigned       INST_W   = S_INST_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [3:0]        HALT_OP  = OP_HALT
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] pc_o,
  input  logic [INST_W-1:0] inst_i,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_target,
  output logic [INST_W-1:0] ir_o,
  output logic [ADDR_W-1:0] ir_pc_o,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic              halted_o
);

  logic load;
  logic is_halt;

  assign is_halt = (inst_i[OP_MSB:OP_LSB] == HALT_OP);

`ifdef FETCH_HALT_EN
  fetch_state_e state;

  assign load = (state == StRun) && (!ir_valid || ir_ready);
`else
  logic unused_is_halt;

  assign unused_is_halt = is_halt;
  assign load           = !ir_valid || ir_ready;
  assign halted_o       = 1'b0;
`endif

  pc_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_counter (
    .clk      (clk),
    .rst      (rst),
    .load_en  (br_valid),
    .load_val (br_target),
    .inc      (load),
    .pc       (pc_o)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_o     <= '0;
      ir_pc_o  <= '0;
      ir_valid <= 1'b0;
`ifdef FETCH_HALT_EN
      state    <= StRun;
      halted_o <= 1'b0;
`endif
    end else if (br_valid) begin
      // Any word handed off this cycle is treated as consumed.
      ir_valid <= 1'b0;
`ifdef FETCH_HALT_EN
      state    <= StRun;
      halted_o <= 1'b0;
`endif
    end else if (load) begin
      ir_o     <= inst_i;
      ir_pc_o  <= pc_o;
      ir_valid <= 1'b1;
`ifdef FETCH_HALT_EN
      if (is_halt) begin
        state    <= StHalt;
        halted_o <= 1'b1;
      end
`endif
    end else if (ir_ready) begin
      // Only reachable in HALT: the final word drains without a refill.
      ir_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit against a combinational instruction memory model.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [7:0]  pc_o;
  logic [15:0] inst_i;
  logic        br_valid;
  logic [7:0]  br_target;
  logic [15:0] ir_o;
  logic [7:0]  ir_pc_o;
  logic        ir_valid;
  logic        ir_ready;
  logic        halted_o;

  logic [15:0] mem [256];
  int          n_checks;
  int          n_fails;

  fetch_unit dut (
    .clk       (clk),
    .rst       (rst),
    .pc_o      (pc_o),
    .inst_i    (inst_i),
    .br_valid  (br_valid),
    .br_target (br_target),
    .ir_o      (ir_o),
    .ir_pc_o   (ir_pc_o),
    .ir_valid  (ir_valid),
    .ir_ready  (ir_ready),
    .halted_o  (halted_o)
  );

  assign inst_i = mem[pc_o];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full IR snapshot: valid, fetch address, word, next pc.
  task automatic check_ir(input string tag, input logic v, input logic [7:0] ipc,
                          input logic [7:0] npc);
    check({tag, ".valid"}, 32'(ir_valid), 32'(v));
    check({tag, ".ir_pc"}, 32'(ir_pc_o), 32'(ipc));
    check({tag, ".ir"},    32'(ir_o),    32'(mem[ipc]));
    check({tag, ".pc"},    32'(pc_o),    32'(npc));
  endtask

  initial begin
    n_checks  = 0;
    n_fails   = 0;
    rst       = 1'b1;
    br_valid  = 1'b0;
    br_target = 8'h00;
    ir_ready  = 1'b1;
    for (int a = 0; a < 256; a++) mem[a] = 16'h2000 | 16'(a);
    mem[7] = 16'h8000;

    // Reset state
    #2;
    check("rst.pc",     32'(pc_o),     32'h00);
    check("rst.valid",  32'(ir_valid), 32'h0);
    check("rst.ir",     32'(ir_o),     32'h0);
    check("rst.ir_pc",  32'(ir_pc_o),  32'h0);
    check("rst.halted", 32'(halted_o), 32'h0);
    tick();
    @(negedge clk);
    rst = 1'b0;
    check("run.pc0", 32'(pc_o), 32'h00);

    // Streaming at one word per cycle
    tick(); check_ir("run1", 1'b1, 8'h00, 8'h01);
    tick(); check_ir("run2", 1'b1, 8'h01, 8'h02);
    tick(); check_ir("run3", 1'b1, 8'h02, 8'h03);

    // Backpressure for three cycles: word and pc held
    ir_ready = 1'b0;
    tick(); check_ir("bp1", 1'b1, 8'h02, 8'h03);
    tick(); check_ir("bp2", 1'b1, 8'h02, 8'h03);
    tick(); check_ir("bp3", 1'b1, 8'h02, 8'h03);
    ir_ready = 1'b1;
    tick(); check_ir("rel1", 1'b1, 8'h03, 8'h04);
    tick(); check_ir("rel2", 1'b1, 8'h04, 8'h05);

    // Branch while a word is being handed off
    br_valid  = 1'b1;
    br_target = 8'h40;
    tick();
    br_valid = 1'b0;
    check("br.valid", 32'(ir_valid), 32'h0);
    check("br.pc",    32'(pc_o),     32'h40);
    tick(); check_ir("br1", 1'b1, 8'h40, 8'h41);

    // PC wrap
    br_valid  = 1'b1;
    br_target = 8'hFF;
    tick();
    br_valid = 1'b0;
    check("wrap.valid", 32'(ir_valid), 32'h0);
    check("wrap.pc",    32'(pc_o),     32'hFF);
    tick(); check_ir("wrap1", 1'b1, 8'hFF, 8'h00);
    tick(); check_ir("wrap2", 1'b1, 8'h00, 8'h01);

    // Run into the HALT opcode at address 7
    br_valid  = 1'b1;
    br_target = 8'h05;
    tick();
    br_valid = 1'b0;
    tick(); check_ir("h5", 1'b1, 8'h05, 8'h06);
    tick(); check_ir("h6", 1'b1, 8'h06, 8'h07);
    tick(); check_ir("h7", 1'b1, 8'h07, 8'h08);
`ifdef FETCH_HALT_EN
    check("h7.halted", 32'(halted_o), 32'h1);
    tick();
    check("hlt.valid",  32'(ir_valid), 32'h0);
    check("hlt.pc",     32'(pc_o),     32'h08);
    check("hlt.halted", 32'(halted_o), 32'h1);
    tick();
    check("hlt2.valid", 32'(ir_valid), 32'h0);
    check("hlt2.pc",    32'(pc_o),     32'h08);
    br_valid  = 1'b1;
    br_target = 8'h00;
    tick();
    br_valid = 1'b0;
    check("res.halted", 32'(halted_o), 32'h0);
    check("res.pc",     32'(pc_o),     32'h00);
    check("res.valid",  32'(ir_valid), 32'h0);
    tick(); check_ir("res1", 1'b1, 8'h00, 8'h01);
`else
    check("h7.halted", 32'(halted_o), 32'h0);
    tick(); check_ir("h8", 1'b1, 8'h08, 8'h09);
    check("h8.halted", 32'(halted_o), 32'h0);
`endif

    // Async reset in the middle of a stall takes effect before the next edge
    ir_ready = 1'b0;
    tick();
    check("stall.valid", 32'(ir_valid), 32'h1);
    #1;
    rst = 1'b1;
    #1;
    check("arst.valid", 32'(ir_valid), 32'h0);
    check("arst.pc",    32'(pc_o),     32'h00);
    check("arst.ir",    32'(ir_o),     32'h0);
    tick();
    check("arst2.valid", 32'(ir_valid), 32'h0);
    check("arst2.pc",    32'(pc_o),     32'h00);
    @(negedge clk);
    rst      = 1'b0;
    ir_ready = 1'b1;
    tick(); check_ir("post", 1'b1, 8'h00, 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
